imem_fetch_ctrl: RTL

//  Sequences the single-port instruction memory of the 32-bit MIPS core.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_fetch_fifo.sv | 46 ++++
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFC00_0000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instruction} entries.
// Clear has priority over push; the head is read combinationally.
module imem_fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wptr] <= din;
  end

  assign count = cnt;
  assign head  = mem[rptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: program load, sequential prefetch into a small
// buffer, valid/ready delivery to decode, redirect flush and HALT detection.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned          BUF_DEPTH  = 2,
  parameter logic [DATA_W-1:0]    HALT_INSTR = DATA_W'(HALT_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              halted
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_nx;
  logic [ADDR_W-1:0] last_addr;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              clear;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_instr;

  assign head_pc    = head[ENT_W-1 -: ADDR_W];
  assign head_instr = head[DATA_W-1:0];

  // State register; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      fetch_pc  <= RESET_PC;
      inflight  <= 1'b0;
      last_addr <= '0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      inflight  <= issue;
      last_addr <= mem_addr;
    end
  end

  // Next state, memory port, issue and handshake decisions.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    mem_addr    = last_addr;
    mem_we      = 1'b0;
    issue       = 1'b0;
    clear       = 1'b0;
    if_valid    = 1'b0;
    pop         = 1'b0;
    occ         = OCC_W'(count) + OCC_W'(inflight);
    case (state)
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we   = 1'b1;
          mem_addr = ld_addr & ALIGN_MASK;
        end
        if (ld_done) begin
          state_nx    = ST_RUN;
          fetch_pc_nx = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          // Redirect wins: flush, kill the returning read, no handshake, no issue.
          clear       = 1'b1;
          fetch_pc_nx = redirect_pc & ALIGN_MASK;
        end else begin
          if_valid = (count != '0);
          pop      = if_valid & if_ready;
          if (pop && (head_instr == HALT_INSTR)) begin
            state_nx = ST_HALT;
            clear    = 1'b1;
          end else if ((occ - OCC_W'(pop)) < OCC_W'(BUF_DEPTH)) begin
            issue       = 1'b1;
            mem_addr    = fetch_pc;
            fetch_pc_nx = fetch_pc + ADDR_W'(WORD_BYTES);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // A read issued last cycle left its address in last_addr, which tags the data.
  assign push = inflight & (state == ST_RUN) & ~clear;

  imem_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({last_addr, mem_rdata}),
    .pop   (pop),
    .clear (clear),
    .count (count),
    .head  (head)
  );

  assign ld_ready  = (state == ST_LOAD);
  assign halted    = (state == ST_HALT);
  assign mem_wdata = ld_data;
  assign if_pc     = if_valid ? head_pc : '0;
  assign if_instr  = if_valid ? head_instr : '0;

endmodule
